// File: rtl/comp_bin_seq_if.sv
// Operand/result handshake bundle for comp_bin_seq: valid/ready on the operand side and on the result side.
interface comp_bin_seq_if #(
  parameter int N = 8
);
  logic         i_Valid;
  logic         o_Ready;
  logic [N-1:0] i_A;
  logic [N-1:0] i_B;
  logic [1:0]   i_Mode;
  logic         o_Valid;
  logic         i_Ready;
  logic         o_Mayor;
  logic         o_Igual;
  logic         o_Menor;

  modport master (
    output i_Valid, i_A, i_B, i_Mode, i_Ready,
    input  o_Ready, o_Valid, o_Mayor, o_Igual, o_Menor
  );

  modport slave (
    input  i_Valid, i_A, i_B, i_Mode, i_Ready,
    output o_Ready, o_Valid, o_Mayor, o_Igual, o_Menor
  );
endinterface

// File: rtl/comp_bin_seq.sv
// Digit-serial MSB-first magnitude comparator (unsigned / two's complement / sign-magnitude), W bits per clock.
// Define COMP_BIN_SEQ_EARLY_EXIT_EN to retire on the first differing digit instead of scanning all N/W digits.
module comp_bin_seq #(
  parameter int N = 8,
  parameter int W = 2
) (
  input logic          i_Clk,
  input logic          i_Rst,
  comp_bin_seq_if.slave bus
);
  localparam int DIGITS = N / W;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {DEC_NONE, DEC_GT, DEC_LT} dec_t;

  state_t        state_q, state_d;
  dec_t          dec_q, dec_d, dec_new;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  ka_q, ka_d, kb_q, kb_d;
  logic          mayor_q, mayor_d, igual_q, igual_d, menor_q, menor_d;
  logic [W-1:0]  dig_a, dig_b;
  logic          last_digit;

  // Every format is turned into a key whose unsigned order equals the numeric order.
  function automatic logic [N-1:0] map_key(input logic [N-1:0] v, input logic [1:0] m);
    logic [N-1:0] half, mag;
    half = {1'b1, {(N-1){1'b0}}};
    mag  = {1'b0, v[N-2:0]};
    case (m)
      2'b01:   map_key = {~v[N-1], v[N-2:0]};
      2'b10:   map_key = v[N-1] ? (half - mag) : (half + mag);
      default: map_key = v;
    endcase
  endfunction

  assign bus.o_Ready = (state_q == IDLE) && !i_Rst;
  assign bus.o_Valid = (state_q == DONE);
  assign bus.o_Mayor = mayor_q;
  assign bus.o_Igual = igual_q;
  assign bus.o_Menor = menor_q;

  always_comb begin
    dig_a   = ka_q[int'(cnt_q) * W +: W];
    dig_b   = kb_q[int'(cnt_q) * W +: W];
    dec_new = dec_q;
    if (dec_q == DEC_NONE) begin
      if (dig_a > dig_b)      dec_new = DEC_GT;
      else if (dig_a < dig_b) dec_new = DEC_LT;
    end
`ifdef COMP_BIN_SEQ_EARLY_EXIT_EN
    last_digit = (cnt_q == '0) || (dec_new != DEC_NONE);
`else
    last_digit = (cnt_q == '0);
`endif
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    mayor_d = mayor_q;
    igual_d = igual_q;
    menor_d = menor_q;
    case (state_q)
      IDLE: begin
        if (bus.i_Valid) begin
          state_d = RUN;
          ka_d    = map_key(bus.i_A, bus.i_Mode);
          kb_d    = map_key(bus.i_B, bus.i_Mode);
          dec_d   = DEC_NONE;
          cnt_d   = CW'(DIGITS - 1);
        end
      end
      RUN: begin
        dec_d = dec_new;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (last_digit) begin
          state_d = DONE;
          mayor_d = (dec_new == DEC_GT);
          menor_d = (dec_new == DEC_LT);
          igual_d = (dec_new == DEC_NONE);
        end
      end
      DONE: begin
        if (bus.i_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result flags: reset aborts any in-flight comparison.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      dec_q   <= DEC_NONE;
      cnt_q   <= '0;
      mayor_q <= 1'b0;
      igual_q <= 1'b0;
      menor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      mayor_q <= mayor_d;
      igual_q <= igual_d;
      menor_q <= menor_d;
    end
  end

  // Key registers are pure data; they are always reloaded at acceptance.
  always_ff @(posedge i_Clk) begin
    ka_q <= ka_d;
    kb_q <= kb_d;
  end
endmodule

// File: tb/tb_comp_bin_seq.sv
// Self-checking bench for comp_bin_seq: directed table, multi-cycle corner sequences and randomized operands.
module tb_comp_bin_seq;
  localparam int N = 8;
  localparam int W = 2;
  localparam int DIGITS = N / W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comp_bin_seq_if #(.N(N)) bus ();

  comp_bin_seq #(.N(N), .W(W)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   mode;
    logic [2:0]   flags;  // {mayor, igual, menor}
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Numeric value of an operand under the given format.
  function automatic int ref_val(input logic [N-1:0] v, input logic [1:0] m);
    int mag;
    case (m)
      2'b01: return int'($signed(v));
      2'b10: begin
        mag = int'(v[N-2:0]);
        return v[N-1] ? -mag : mag;
      end
      default: return int'(v);
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [1:0] m);
    int va, vb;
    va = ref_val(a, m);
    vb = ref_val(b, m);
    return {va > vb, va == vb, va < vb};
  endfunction

  function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [1:0] m);
`ifdef COMP_BIN_SEQ_EARLY_EXIT_EN
    int off, ka, kb, da, db;
    off = (m == 2'b01 || m == 2'b10) ? (1 << (N - 1)) : 0;
    ka  = ref_val(a, m) + off;
    kb  = ref_val(b, m) + off;
    for (int d = 1; d <= DIGITS; d++) begin
      da = (ka >> (N - d * W)) & ((1 << W) - 1);
      db = (kb >> (N - d * W)) & ((1 << W) - 1);
      if (da != db) return d;
    end
    return DIGITS;
`else
    return DIGITS;
`endif
  endfunction

  function automatic logic [2:0] flags_now();
    return {bus.o_Mayor, bus.o_Igual, bus.o_Menor};
  endfunction

  // Issue one operand pair, check latency and flags, optionally stall the result for `hold` cycles.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] m,
                        input logic [2:0] e, input int hold, input string tag);
    int lat, el;
    el = exp_lat(a, b, m);
    @(negedge clk);
    chk({tag, " ready"}, bus.o_Ready, 1);
    bus.i_Valid = 1'b1;
    bus.i_A     = a;
    bus.i_B     = b;
    bus.i_Mode  = m;
    bus.i_Ready = 1'b0;
    @(negedge clk);
    bus.i_Valid = 1'b0;
    bus.i_A     = N'($urandom);
    bus.i_B     = N'($urandom);
    bus.i_Mode  = 2'($urandom);
    lat = 0;
    while (!bus.o_Valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, el);
    chk({tag, " flags"}, flags_now(), e);
    for (int i = 0; i < hold; i++) begin
      bus.i_Valid = 1'b1;
      @(negedge clk);
      chk({tag, " stall valid"}, bus.o_Valid, 1);
      chk({tag, " stall flags"}, flags_now(), e);
      chk({tag, " stall ready"}, bus.o_Ready, 0);
    end
    bus.i_Ready = 1'b1;
    @(negedge clk);
    bus.i_Ready = 1'b0;
    bus.i_Valid = 1'b0;
    chk({tag, " retire valid"}, bus.o_Valid, 0);
    chk({tag, " retire ready"}, bus.o_Ready, 1);
    if (hold > 0) begin
      @(negedge clk);
      chk({tag, " no accept in retire"}, bus.o_Ready, 1);
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic [1:0]   rm;

    vecs.push_back('{8'hA5, 8'h5A, 2'b00, 3'b100});
    vecs.push_back('{8'h80, 8'h7F, 2'b01, 3'b001});
    vecs.push_back('{8'h80, 8'h7F, 2'b00, 3'b100});
    vecs.push_back('{8'h80, 8'h00, 2'b10, 3'b010});
    vecs.push_back('{8'h85, 8'h83, 2'b10, 3'b001});
    vecs.push_back('{8'h01, 8'h81, 2'b10, 3'b100});
    vecs.push_back('{8'h80, 8'h7F, 2'b11, 3'b100});
    vecs.push_back('{8'h40, 8'h00, 2'b00, 3'b100});
    vecs.push_back('{8'h3C, 8'h3C, 2'b00, 3'b010});
    vecs.push_back('{8'hFF, 8'hFF, 2'b01, 3'b010});
    vecs.push_back('{8'h00, 8'h80, 2'b10, 3'b010});
    vecs.push_back('{8'h3C, 8'h3D, 2'b00, 3'b001});

    rst         = 1'b1;
    bus.i_Valid = 1'b0;
    bus.i_Ready = 1'b0;
    bus.i_A     = '0;
    bus.i_B     = '0;
    bus.i_Mode  = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset ready", bus.o_Ready, 0);
    chk("reset valid", bus.o_Valid, 0);
    chk("reset flags", flags_now(), 3'b000);
    rst = 1'b0;
    #1;
    chk("post-reset ready", bus.o_Ready, 1);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].flags, 0, $sformatf("vec%0d", i));

    run_op(8'hA5, 8'h5A, 2'b00, 3'b100, 10, "backpressure");

    // Reset while the comparison is still in RUN.
    @(negedge clk);
    bus.i_Valid = 1'b1;
    bus.i_A     = 8'h3C;
    bus.i_B     = 8'h3C;
    bus.i_Mode  = 2'b00;
    @(negedge clk);
    bus.i_Valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun reset valid", bus.o_Valid, 0);
    chk("midrun reset flags", flags_now(), 3'b000);
    chk("midrun reset ready", bus.o_Ready, 0);
    rst = 1'b0;
    #1;
    chk("midrun post-reset ready", bus.o_Ready, 1);
    run_op(8'h85, 8'h83, 2'b10, 3'b001, 0, "after reset");

    // Reset while a result is held in DONE.
    @(negedge clk);
    bus.i_Valid = 1'b1;
    bus.i_A     = 8'h10;
    bus.i_B     = 8'h20;
    bus.i_Mode  = 2'b00;
    @(negedge clk);
    bus.i_Valid = 1'b0;
    repeat (DIGITS + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("done reset valid", bus.o_Valid, 0);
    chk("done reset flags", flags_now(), 3'b000);

    for (int i = 0; i < 150; i++) begin
      ra = N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
      rm = 2'($urandom);
      run_op(ra, rb, rm, ref_flags(ra, rb, rm), $urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
